// File: rtl/sm_pkg.sv
// sm_pkg -- shared definitions for the sign-magnitude add arbiter slice.
//   DEFAULT_N : default operand width (1 sign bit + N-1 magnitude bits)
//   state_t   : result-slot state, IDLE (slot empty) / HOLD (result valid)
package sm_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/sm_add_arbiter_if.sv
// sm_add_arbiter_if -- request/response bundle between two requesters,
// the shared adder and the result consumer.
//   req_valid[1:0] / req_ready[1:0] : per-requester request handshake
//   a0, b0, a1, b1                  : sign-magnitude operands per requester
//   rsp_valid / rsp_ready           : result handshake
//   rsp_data, rsp_id, rsp_ovf       : sum, owning requester, overflow flag
// Modports: master = requesters + consumer side, slave = the arbiter.
interface sm_add_arbiter_if #(
  parameter int N = sm_pkg::DEFAULT_N
);

  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [N-1:0] a0;
  logic [N-1:0] b0;
  logic [N-1:0] a1;
  logic [N-1:0] b1;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_data;
  logic         rsp_id;
  logic         rsp_ovf;

  modport master (
    output req_valid, a0, b0, a1, b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf
  );

  modport slave (
    input  req_valid, a0, b0, a1, b1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf
  );

endinterface

// File: rtl/sign_mag_add.sv
// sign_mag_add -- combinational sign-magnitude adder.
//   i_a, i_b : N-bit sign-magnitude operands (MSB = sign)
//   o_sign   : raw sign of the result (may be 1 for a zero magnitude)
//   o_mag    : N-bit raw magnitude; bit N-1 is the carry out of a
//              same-sign add, so callers can detect overflow themselves
module sign_mag_add #(
  parameter int N = sm_pkg::DEFAULT_N
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_sign,
  output logic [N-1:0] o_mag
);

  logic [N-1:0] w_magA;
  logic [N-1:0] w_magB;

  // Same signs add magnitudes; differing signs subtract the smaller
  // magnitude from the larger and take the larger operand's sign.
  always_comb begin
    w_magA = {1'b0, i_a[N-2:0]};
    w_magB = {1'b0, i_b[N-2:0]};
    o_sign = i_a[N-1];
    o_mag  = '0;
    if (i_a[N-1] == i_b[N-1]) begin
      o_mag  = w_magA + w_magB;
    end else if (w_magA >= w_magB) begin
      o_mag  = w_magA - w_magB;
    end else begin
      o_sign = i_b[N-1];
      o_mag  = w_magB - w_magA;
    end
  end

endmodule

// File: rtl/sm_add_arbiter.sv
// sm_add_arbiter -- two requesters share one sign-magnitude adder through
// round-robin arbitration; one registered result slot with a handshake.
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset
//   bus   : sm_add_arbiter_if slave modport (request/response signals)
module sm_add_arbiter
  import sm_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input logic             clk,
  input logic             reset,
  sm_add_arbiter_if.slave bus
);

  state_t       r_state;
  state_t       w_stateNext;
  logic         r_rrLast;
  logic [N-1:0] r_data;
  logic         r_id;
  logic         r_ovf;

  logic         w_slotFree;
  logic         w_grantIdx;
  logic [1:0]   w_reqReady;
  logic         w_transfer;
  logic [N-1:0] w_opA;
  logic [N-1:0] w_opB;
  logic         w_sign;
  logic [N-1:0] w_mag;
  logic [N-2:0] w_resMag;
  logic         w_ovf;
  logic [N-1:0] w_resData;

  // The slot is free when empty or when the held result leaves this cycle.
  // On a tie the requester not granted last time wins; reset blocks grants.
  always_comb begin
    w_slotFree = !reset && ((r_state == IDLE) || bus.rsp_ready);
    if (bus.req_valid == 2'b11) begin
      w_grantIdx = ~r_rrLast;
    end else begin
      w_grantIdx = bus.req_valid[1];
    end
    w_reqReady = 2'b00;
    if (w_slotFree && (|bus.req_valid)) begin
      w_reqReady[w_grantIdx] = 1'b1;
    end
    w_transfer = |(bus.req_valid & w_reqReady);
  end

  assign w_opA = w_grantIdx ? bus.a1 : bus.a0;
  assign w_opB = w_grantIdx ? bus.b1 : bus.b0;

  sign_mag_add #(.N(N)) u_adder (
    .i_a    (w_opA),
    .i_b    (w_opB),
    .o_sign (w_sign),
    .o_mag  (w_mag)
  );

  // Overflow is only possible when signs agree (carry out of the magnitude).
  // A truncated zero magnitude is always emitted as positive zero.
  always_comb begin
    w_resMag  = w_mag[N-2:0];
    w_ovf     = (w_opA[N-1] == w_opB[N-1]) && w_mag[N-1];
    w_resData = {w_sign && (w_resMag != '0), w_resMag};
  end

  // State register for the result slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: a transfer always fills the slot; an accepted result with
  // no replacement empties it.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: if (w_transfer) w_stateNext = HOLD;
      HOLD: if (bus.rsp_ready && !w_transfer) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Result registers and round-robin pointer load only on a transfer,
  // which keeps them stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data   <= '0;
      r_id     <= 1'b0;
      r_ovf    <= 1'b0;
      r_rrLast <= 1'b1;
    end else if (w_transfer) begin
      r_data   <= w_resData;
      r_id     <= w_grantIdx;
      r_ovf    <= w_ovf;
      r_rrLast <= w_grantIdx;
    end
  end

  assign bus.req_ready = w_reqReady;
  assign bus.rsp_valid = (r_state == HOLD);
  assign bus.rsp_data  = r_data;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_ovf   = r_ovf;

endmodule

// File: tb/tb_sm_add_arbiter.sv
// tb_sm_add_arbiter -- directed self-checking bench for sm_add_arbiter, N=4.
// Inputs change on the falling edge; req_ready is sampled 1ns later and the
// registered outputs 1ns after the rising edge.
module tb_sm_add_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  sm_add_arbiter_if #(.N(4)) bus ();

  sm_add_arbiter #(.N(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset held with both requesters asking: no grant, all outputs zero.
  task automatic test_reset();
    reset         = 1'b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b0;
    bus.a0 = 4'b0001; bus.b0 = 4'b0001;
    bus.a1 = 4'b0001; bus.b1 = 4'b0001;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (bus.req_ready !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_req_ready: got %b expected 00", bus.req_ready);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_ovf} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got v=%b d=%b id=%b ovf=%b expected all 0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_ovf);
    end
    bus.req_valid = 2'b00;
    reset = 1'b0;
  endtask

  // Both requesters valid continuously: grants 0,1,0,1, one result per cycle.
  // Requester 0: +1 + +1 = 0010; requester 1: +2 + -1 = 0001.
  task automatic test_alternate();
    logic [1:0] expReady;
    logic [3:0] expData;
    @(negedge clk);
    bus.a0 = 4'b0001; bus.b0 = 4'b0001;
    bus.a1 = 4'b0010; bus.b1 = 4'b1001;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expReady = (i % 2 == 0) ? 2'b01 : 2'b10;
      expData  = (i % 2 == 0) ? 4'b0010 : 4'b0001;
      #1;
      checks++;
      if (bus.req_ready !== expReady) begin
        failures++;
        $display("[TB] FAIL alt_grant[%0d]: got %b expected %b", i, bus.req_ready, expReady);
      end
      @(posedge clk); #1;
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, expReady[1], expData}) begin
        failures++;
        $display("[TB] FAIL alt_rsp[%0d]: got v=%b id=%b d=%b expected v=1 id=%b d=%b",
                 i, bus.rsp_valid, bus.rsp_id, bus.rsp_data, expReady[1], expData);
      end
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL alt_drain: got rsp_valid=%b expected 0", bus.rsp_valid);
    end
  endtask

  // Single-requester sums back to back: mixed signs, overflow, zero result.
  task automatic test_single();
    logic [1:0] vReq [3];
    logic [3:0] vA [3];
    logic [3:0] vB [3];
    logic [3:0] vData [3];
    logic       vOvf [3];
    vReq[0] = 2'b01; vA[0] = 4'b0011; vB[0] = 4'b1101; vData[0] = 4'b1010; vOvf[0] = 1'b0;
    vReq[1] = 2'b10; vA[1] = 4'b0101; vB[1] = 4'b0100; vData[1] = 4'b0001; vOvf[1] = 1'b1;
    vReq[2] = 2'b01; vA[2] = 4'b0011; vB[2] = 4'b1011; vData[2] = 4'b0000; vOvf[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.req_valid = vReq[i];
      bus.rsp_ready = 1'b1;
      if (vReq[i][1]) begin
        bus.a1 = vA[i]; bus.b1 = vB[i];
        bus.a0 = 4'b0111; bus.b0 = 4'b0111;
      end else begin
        bus.a0 = vA[i]; bus.b0 = vB[i];
        bus.a1 = 4'b0111; bus.b1 = 4'b0111;
      end
      #1;
      checks++;
      if (bus.req_ready !== vReq[i]) begin
        failures++;
        $display("[TB] FAIL single_grant[%0d]: got %b expected %b", i, bus.req_ready, vReq[i]);
      end
      @(posedge clk); #1;
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_ovf} !==
          {1'b1, vData[i], vReq[i][1], vOvf[i]}) begin
        failures++;
        $display("[TB] FAIL single_rsp[%0d]: got v=%b d=%b id=%b ovf=%b expected v=1 d=%b id=%b ovf=%b",
                 i, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_ovf,
                 vData[i], vReq[i][1], vOvf[i]);
      end
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(posedge clk);
  endtask

  // Consumer stalls 3 cycles: no grant, result held; then release accepts
  // the waiting request in the same cycle.
  task automatic test_backpressure();
    @(negedge clk);
    bus.a0 = 4'b0010; bus.b0 = 4'b0001;
    bus.req_valid = 2'b01;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.a0 = 4'b0100; bus.b0 = 4'b0001;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.req_ready !== 2'b00) begin
        failures++;
        $display("[TB] FAIL stall_ready[%0d]: got %b expected 00", i, bus.req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 4'b0011}) begin
        failures++;
        $display("[TB] FAIL stall_hold[%0d]: got v=%b d=%b expected v=1 d=0011",
                 i, bus.rsp_valid, bus.rsp_data);
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++;
      $display("[TB] FAIL release_ready: got %b expected 01", bus.req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 4'b0101}) begin
      failures++;
      $display("[TB] FAIL release_rsp: got v=%b d=%b expected v=1 d=0101",
               bus.rsp_valid, bus.rsp_data);
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(posedge clk);
  endtask

  // Reset during HOLD discards the result and restores the tie winner to 0
  // (without reset the pointer would give this tie to requester 1).
  task automatic test_reset_mid_hold();
    @(negedge clk);
    bus.a0 = 4'b1011; bus.b0 = 4'b1001;
    bus.a1 = 4'b0001; bus.b1 = 4'b0010;
    bus.req_valid = 2'b01;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 4'b1100}) begin
      failures++;
      $display("[TB] FAIL pre_reset_rsp: got v=%b d=%b expected v=1 d=1100",
               bus.rsp_valid, bus.rsp_data);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 2'b00) begin
      failures++;
      $display("[TB] FAIL mid_reset_ready: got %b expected 00", bus.req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_ovf} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset_outputs: got v=%b d=%b id=%b ovf=%b expected all 0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_ovf);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++;
      $display("[TB] FAIL post_reset_tie: got %b expected 01", bus.req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b0, 4'b1100}) begin
      failures++;
      $display("[TB] FAIL post_reset_rsp: got v=%b id=%b d=%b expected v=1 id=0 d=1100",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_alternate();
    test_single();
    test_backpressure();
    test_reset_mid_hold();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
